// File: rtl/matmul_pkg.sv
// Purpose: shared types and constants for the systolic-array arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arb_state_t (arbiter FSM states), MATMUL_DIM (array edge),
// NUM_REQ_DEF (default requester count).
package matmul_pkg;

  localparam int MATMUL_DIM  = 8;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/matmul_arbiter_if.sv
// Purpose: bundles the requester-side and controller-side handshakes of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: carries the valid/ready pairs; no buffering.
//
// Modports: slave = arbiter (consumes req/valids/ctrl status, drives grant/readies/start),
//           master = requesters + controller model (the opposite directions).
interface matmul_arbiter_if #(
  parameter int NUM_REQ = matmul_pkg::NUM_REQ_DEF
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] req_a_valid;
  logic [NUM_REQ-1:0] req_b_valid;
  logic [NUM_REQ-1:0] req_a_ready;
  logic [NUM_REQ-1:0] req_b_ready;
  logic [NUM_REQ-1:0] req_read_valid;
  logic [NUM_REQ-1:0] req_c_valid;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] res_ack;
  logic               ctrl_ready;
  logic               ctrl_done;
  logic               ctrl_start;
  logic               ctrl_a_valid;
  logic               ctrl_b_valid;
  logic               ctrl_read_valid;
  logic               ctrl_a_ready;
  logic               ctrl_b_ready;
  logic               ctrl_c_valid;

  modport slave (
    input  req, req_a_valid, req_b_valid, req_read_valid, res_ack,
           ctrl_ready, ctrl_done, ctrl_a_ready, ctrl_b_ready, ctrl_c_valid,
    output grant, grant_id, req_a_ready, req_b_ready, req_c_valid, req_done,
           ctrl_start, ctrl_a_valid, ctrl_b_valid, ctrl_read_valid
  );

  modport master (
    output req, req_a_valid, req_b_valid, req_read_valid, res_ack,
           ctrl_ready, ctrl_done, ctrl_a_ready, ctrl_b_ready, ctrl_c_valid,
    input  grant, grant_id, req_a_ready, req_b_ready, req_c_valid, req_done,
           ctrl_start, ctrl_a_valid, ctrl_b_valid, ctrl_read_valid
  );

endinterface

// File: rtl/rr_picker.sv
// Purpose: pick the first set request bit searching upward from a base index, with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when to register the pick.
//
// Ports: req_i (request vector), base_i (search start), win_o (one-hot winner),
//        idx_o (binary winner index), any_o (at least one request set).
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    base_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] pos;

  // Walk offsets 0..NUM_REQ-1 from base; the first hit latches via any_o.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = ID_W'((int'(base_i) + k) % NUM_REQ);
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        idx_o      = pos;
        win_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_arbiter.sv
// Purpose: shares one systolic-array controller among NUM_REQ requesters, holding the grant until res_ack.
// Latency: req+ctrl_ready -> grant/ctrl_start next cycle; res_ack -> grant clear next cycle; routing is combinational.
// Backpressure: owner sees the controller's readies directly; non-owners see 0 and are never forwarded.
//
// Ports: clk, rst (async, active-low), bus (matmul_arbiter_if.slave: requester and controller handshakes).
// Build option: define MATMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module matmul_arbiter
  import matmul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  matmul_arbiter_if.slave      bus
);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;

  logic [NUM_REQ-1:0]  pick_win;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req_i  (bus.req),
    .base_i (ptr_q),
    .win_o  (pick_win),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ctrl_ready && pick_any) begin
          grant_d    = pick_win;
          grant_id_d = pick_idx;
          state_d    = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (bus.ctrl_done) state_d = HOLD;
      end
      HOLD: begin
        // Only the owner's ack releases; req drops and other acks are ignored.
        if (bus.res_ack[grant_id_q]) begin
          grant_d    = '0;
          grant_id_d = '0;
          state_d    = IDLE;
`ifdef MATMUL_ARB_FIXED_PRIO_EN
          ptr_d      = '0;
`else
          ptr_d      = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state, so reset clears them immediately.
  logic load_act;
  logic read_act;
  assign load_act = (state_q == BUSY);
  assign read_act = (state_q == BUSY) || (state_q == HOLD);

  assign bus.grant           = grant_q;
  assign bus.grant_id        = grant_id_q;
  assign bus.ctrl_start      = (state_q == START);
  assign bus.ctrl_a_valid    = load_act && bus.req_a_valid[grant_id_q];
  assign bus.ctrl_b_valid    = load_act && bus.req_b_valid[grant_id_q];
  assign bus.ctrl_read_valid = read_act && bus.req_read_valid[grant_id_q];
  assign bus.req_a_ready     = load_act ? ({NUM_REQ{bus.ctrl_a_ready}} & grant_q) : '0;
  assign bus.req_b_ready     = load_act ? ({NUM_REQ{bus.ctrl_b_ready}} & grant_q) : '0;
  assign bus.req_c_valid     = (read_act && bus.ctrl_c_valid) ? grant_q : '0;
  assign bus.req_done        = (load_act && bus.ctrl_done) ? grant_q : '0;

endmodule

// File: tb/tb_matmul_arbiter.sv
// Purpose: self-checking bench for matmul_arbiter (grant order, routing, pulses, reset).
// Latency: n/a.
// Backpressure: n/a.
module tb_matmul_arbiter;
  import matmul_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst;

  matmul_arbiter_if #(.NUM_REQ(N)) bus ();

  matmul_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  typedef struct {
    logic [N-1:0] av, bv, rv;
    logic         ca, cb, cc;
    logic         e_cav, e_cbv, e_crv;
    logic [N-1:0] e_ar, e_br, e_cv;
  } vec_t;

  vec_t vecs[5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for ctrl_start and compares the owner with the scoreboard head.
  task automatic wait_grant(input int budget, output int n, output int id);
    n  = 0;
    id = 0;
    while (bus.ctrl_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(bus.ctrl_start), 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_depth", 0, 1);
    end else begin
      id = exp_q.pop_front();
      chk("grant_id", 32'(bus.grant_id), 32'(id));
      chk("grant", 32'(bus.grant), 32'(1) << id);
    end
  endtask

  // Called one cycle after START (state BUSY): done pulse, then owner ack.
  task automatic finish_job(input int id);
    chk("start_single", 32'(bus.ctrl_start), 0);
    bus.ctrl_done = 1'b1;
    #1;
    chk("done_pulse", 32'(bus.req_done), 32'(1) << id);
    tick();
    bus.ctrl_done = 1'b0;
    #1;
    chk("done_single", 32'(bus.req_done), 0);
    bus.res_ack = N'(1 << id);
    tick();
    bus.res_ack = '0;
    chk("release_grant", 32'(bus.grant), 0);
    chk("release_no_start", 32'(bus.ctrl_start), 0);
  endtask

  task automatic clear_inputs();
    bus.req            = '0;
    bus.req_a_valid    = '0;
    bus.req_b_valid    = '0;
    bus.req_read_valid = '0;
    bus.res_ack        = '0;
    bus.ctrl_ready     = 1'b0;
    bus.ctrl_done      = 1'b0;
    bus.ctrl_a_ready   = 1'b0;
    bus.ctrl_b_ready   = 1'b0;
    bus.ctrl_c_valid   = 1'b0;
  endtask

  initial begin
    int n;
    int id;

    //            av       bv       rv       ca cb cc  cav cbv crv  ar       br       cv
    vecs[0] = '{4'b1111, 4'b0000, 4'b0000, 1, 0, 0,  1,  0,  0,  4'b0010, 4'b0000, 4'b0000};
    vecs[1] = '{4'b1101, 4'b0010, 4'b1111, 1, 1, 1,  0,  1,  1,  4'b0010, 4'b0010, 4'b0010};
    vecs[2] = '{4'b1111, 4'b1111, 4'b1101, 0, 0, 1,  1,  1,  0,  4'b0000, 4'b0000, 4'b0010};
    vecs[3] = '{4'b0010, 4'b1101, 4'b0010, 0, 1, 0,  1,  0,  1,  4'b0000, 4'b0010, 4'b0000};
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 1, 1, 1,  0,  0,  0,  4'b0010, 4'b0010, 4'b0010};

    rst = 1'b1;
    clear_inputs();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state: outputs stay 0 even with inputs poked.
    bus.req_a_valid    = '1;
    bus.req_read_valid = '1;
    bus.ctrl_a_ready   = 1'b1;
    bus.ctrl_c_valid   = 1'b1;
    bus.ctrl_done      = 1'b1;
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_start", 32'(bus.ctrl_start), 0);
    chk("rst_a_valid", 32'(bus.ctrl_a_valid), 0);
    chk("rst_a_ready", 32'(bus.req_a_ready), 0);
    chk("rst_c_valid", 32'(bus.req_c_valid), 0);
    chk("rst_done", 32'(bus.req_done), 0);
    clear_inputs();
    rst = 1'b1;
    tick();

    // Single request.
    bus.ctrl_ready = 1'b1;
    bus.req = 4'b0100;
    exp_q.push_back(2);
    wait_grant(10, n, id);
    chk("arb_latency", 32'(n), 1);
    tick();
    finish_job(id);
    bus.req = '0;

    // Round-robin fairness from a fresh pointer.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
`ifdef MATMUL_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
`endif
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(10, n, id);
      chk("rr_latency", 32'(n), 1);
      tick();
      finish_job(id);
    end
    bus.req = '0;

    // Handshake isolation with owner 1.
    bus.req = 4'b0010;
    exp_q.push_back(1);
    wait_grant(10, n, id);
    tick();
    for (int v = 0; v < 5; v++) begin
      bus.req_a_valid    = vecs[v].av;
      bus.req_b_valid    = vecs[v].bv;
      bus.req_read_valid = vecs[v].rv;
      bus.ctrl_a_ready   = vecs[v].ca;
      bus.ctrl_b_ready   = vecs[v].cb;
      bus.ctrl_c_valid   = vecs[v].cc;
      #1;
      chk("vec_ctrl_a_valid", 32'(bus.ctrl_a_valid), 32'(vecs[v].e_cav));
      chk("vec_ctrl_b_valid", 32'(bus.ctrl_b_valid), 32'(vecs[v].e_cbv));
      chk("vec_ctrl_read_valid", 32'(bus.ctrl_read_valid), 32'(vecs[v].e_crv));
      chk("vec_req_a_ready", 32'(bus.req_a_ready), 32'(vecs[v].e_ar));
      chk("vec_req_b_ready", 32'(bus.req_b_ready), 32'(vecs[v].e_br));
      chk("vec_req_c_valid", 32'(bus.req_c_valid), 32'(vecs[v].e_cv));
    end
    bus.req_a_valid = '0; bus.req_b_valid = '0; bus.req_read_valid = '0;
    bus.ctrl_a_ready = 1'b0; bus.ctrl_b_ready = 1'b0; bus.ctrl_c_valid = 1'b0;
    bus.ctrl_done = 1'b1;
    #1;
    chk("own1_done", 32'(bus.req_done), 32'h2);
    tick();
    bus.ctrl_done = 1'b0;
    // HOLD: loads gated off, C path still routed.
    bus.req_a_valid = '1; bus.ctrl_a_ready = 1'b1;
    bus.req_read_valid = '1; bus.ctrl_c_valid = 1'b1;
    #1;
    chk("hold_a_valid", 32'(bus.ctrl_a_valid), 0);
    chk("hold_a_ready", 32'(bus.req_a_ready), 0);
    chk("hold_read_valid", 32'(bus.ctrl_read_valid), 1);
    chk("hold_c_valid", 32'(bus.req_c_valid), 32'h2);
    clear_inputs();
    bus.ctrl_ready = 1'b1;
    bus.res_ack = 4'b0010;
    tick();
    bus.res_ack = '0;
    chk("own1_release", 32'(bus.grant), 0);

    // Done pulse and non-owner ack with owner 3.
    bus.req = 4'b1000;
    exp_q.push_back(3);
    wait_grant(10, n, id);
    tick();
    bus.ctrl_done = 1'b1;
    #1;
    chk("own3_done", 32'(bus.req_done), 32'h8);
    tick();
    bus.ctrl_done = 1'b0;
    #1;
    chk("own3_done_single", 32'(bus.req_done), 0);
    bus.ctrl_done = 1'b1;
    #1;
    chk("done_in_hold", 32'(bus.req_done), 0);
    tick();
    bus.ctrl_done = 1'b0;
    bus.res_ack = 4'b0001;
    tick();
    bus.res_ack = '0;
    chk("nonowner_ack", 32'(bus.grant), 32'h8);
    bus.req = '0;
    tick();
    chk("req_drop_held", 32'(bus.grant), 32'h8);
    bus.ctrl_c_valid = 1'b1;
    #1;
    chk("req_drop_c_route", 32'(bus.req_c_valid), 32'h8);
    bus.ctrl_c_valid = 1'b0;
    bus.res_ack = 4'b1000;
    tick();
    bus.res_ack = '0;
    chk("own3_release", 32'(bus.grant), 0);

    // Controller not ready.
    bus.ctrl_ready = 1'b0;
    bus.req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("nrdy_grant", 32'(bus.grant), 0);
      chk("nrdy_start", 32'(bus.ctrl_start), 0);
    end
    bus.ctrl_ready = 1'b1;
    exp_q.push_back(0);
    wait_grant(10, n, id);
    chk("nrdy_latency", 32'(n), 1);
    tick();
    finish_job(id);
    bus.req = '0;

    // Reset mid-job (pointer is 1 before the reset).
    bus.req = 4'b0100;
    exp_q.push_back(2);
    wait_grant(10, n, id);
    tick();
    bus.req = '0;
    bus.req_a_valid = '1; bus.ctrl_a_ready = 1'b1;
    bus.req_read_valid = '1; bus.ctrl_c_valid = 1'b1;
    #1;
    chk("busy_a_valid", 32'(bus.ctrl_a_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_grant_id", 32'(bus.grant_id), 0);
    chk("mid_rst_a_valid", 32'(bus.ctrl_a_valid), 0);
    chk("mid_rst_a_ready", 32'(bus.req_a_ready), 0);
    chk("mid_rst_c_valid", 32'(bus.req_c_valid), 0);
    chk("mid_rst_read_valid", 32'(bus.ctrl_read_valid), 0);
    clear_inputs();
    tick();
    rst = 1'b1;
    bus.ctrl_ready = 1'b1;
    bus.req = 4'b1111;
    exp_q.push_back(0);
    wait_grant(10, n, id);
    chk("post_rst_latency", 32'(n), 1);
    tick();
    finish_job(id);
    bus.req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
